// File: rtl/imem_loader.sv
// imem_loader -- fills the 24-bit instruction memory from a host byte stream.
//
// Stream format: 16-bit word count N (MSB first), then N words of three bytes
// each, most significant byte first. Each assembled word is written to
// BASE_ADDR + index with a single-cycle mem_we pulse. The core is held in
// stall (cpu_hold=1) until the full image has been written.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte equal to the XOR of every accepted byte, including the two
// length bytes. A mismatch ends in the error state with cpu_hold left high.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   byte_in     host data byte
//   byte_valid  byte_in holds a valid byte
//   byte_ready  loader accepts a byte this cycle
//   mem_addr    instruction memory write address
//   mem_wdata   instruction word to write
//   mem_we      write strobe, one cycle per word
//   cpu_hold    core stall request
//   done        image loaded successfully (level)
//   error       load aborted (level)

module imem_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, B2, B1, B0, WRITE, DONE, ERR, CHK
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, B2, B1, B0, WRITE, DONE, ERR
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count;
    logic [15:0] index;
    logic [15:0] index_inc;
    logic [15:0] len;
    logic [23:0] wdata;
    logic        accept;
    logic        start_take;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Full word count as seen while the low length byte is on the bus.
    assign len        = {count[15:8], byte_in};
    assign index_inc  = index + 16'd1;
    assign accept     = byte_valid && byte_ready;
    assign start_take = start && (state == IDLE || state == DONE || state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            index <= '0;
            wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (start_take) begin
                index <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum  <= '0;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            // start is never taken in a byte-accepting state, so no conflict
            // with the clear above.
            if (accept) begin
                csum <= csum ^ byte_in;
            end
`endif
            if (accept && state == LEN_HI) begin
                count[15:8] <= byte_in;
            end
            if (accept && state == LEN_LO) begin
                count[7:0] <= byte_in;
            end
            if (accept && (state == B2 || state == B1 || state == B0)) begin
                wdata <= {wdata[15:0], byte_in};
            end
            if (state == WRITE) begin
                index <= index_inc;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LEN_HI;
                end
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt = DONE;
`endif
                    end else if (32'(len) > DEPTH) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = B2;
                    end
                end
            end
            B2: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nxt = B1;
                end
            end
            B1: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nxt = B0;
                end
            end
            B0: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                if (index_inc == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = B2;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    // csum has not yet folded in this byte, so it is the
                    // XOR of everything before the checksum.
                    state_nxt = (byte_in == csum) ? DONE : ERR;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(index);
    assign mem_wdata = wdata;
    assign cpu_hold  = (state != DONE);
    assign done      = (state == DONE);
    assign error     = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed bench for imem_loader. A stream-level model
// derives the expected writes and final status from each byte image; a
// negedge monitor checks every write against it.

module tb_imem_loader;

    localparam int ADDR_W    = 16;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 256;

    typedef logic [7:0] u8_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    u8_t               stream[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [23:0]       exp_data_q[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [23:0]       log_data[$];
    bit                exp_done;
    bit                exp_err;
    bit                mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Write monitor: every mem_we cycle must match the next expected write.
    always @(negedge clk) begin
        if (mon_en && reset && mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            chk("ready_low_in_write", 32'(byte_ready), 32'd0);
            chk("hold_during_write", 32'(cpu_hold), 32'd1);
            chk("write_expected", 32'(exp_addr_q.size() > 0), 32'd1);
            if (exp_addr_q.size() > 0) begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                chk("wr_data", 32'(mem_wdata), 32'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic clear_expect();
        exp_addr_q.delete();
        exp_data_q.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic add_ck();
`ifdef IMEM_LOADER_CHECKSUM_EN
        u8_t x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        stream.push_back(x);
`endif
    endtask

    // Derive expected writes and final status straight from the byte image.
    task automatic build_model();
        int  n;
        u8_t x;
        clear_expect();
        n = int'({stream[0], stream[1]});
        x = stream[0] ^ stream[1];
        if (n > DEPTH) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_addr_q.push_back(ADDR_W'(BASE_ADDR + w));
            exp_data_q.push_back({stream[2+3*w], stream[3+3*w], stream[4+3*w]});
            x ^= stream[2+3*w] ^ stream[3+3*w] ^ stream[4+3*w];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_done = (stream[2+3*n] == x);
        exp_err  = !exp_done;
`else
        exp_done = 1'b1;
        exp_err  = 1'b0;
`endif
    endtask

    task automatic pulse_start(input bit with_byte, input u8_t b);
        @(negedge clk);
        chk("ready_low_before_start", 32'(byte_ready), 32'd0);
        start = 1'b1;
        if (with_byte) begin
            byte_valid = 1'b1;
            byte_in    = b;
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(error), 32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_ready", 32'(byte_ready), 32'd1);
    endtask

    // Present the stream; a byte counts as sent once valid&&ready is seen
    // for the cycle, it is then taken on the following rising edge.
    task automatic send_stream(input bit toggle);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b0;
        while (i < stream.size() && cyc < 4000) begin
            @(negedge clk);
            if (toggle && ph) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = stream[i];
            end
            ph = !ph;
            if (byte_valid && byte_ready) i++;
            cyc++;
        end
        chk("stream_consumed", 32'(i), 32'(stream.size()));
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int cyc = 0;
        while (!(done || error) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(BASE_ADDR));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic run_image(input string tag, input bit toggle);
        build_model();
        pulse_start(1'b0, 8'h00);
        send_stream(toggle);
        finish_load(tag);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Two-word image, continuous valid
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        add_ck();
        run_image("t1", 1'b0);
        chk("t1_nwr_lit", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
            chk("t1_a0_lit", 32'(log_addr[0]), 32'd0);
            chk("t1_d0_lit", 32'(log_data[0]), 32'h123456);
            chk("t1_a1_lit", 32'(log_addr[1]), 32'd1);
            chk("t1_d1_lit", 32'(log_data[1]), 32'hABCDEF);
        end
        chk("t1_done_lit", 32'(done), 32'd1);
        chk("t1_hold_lit", 32'(cpu_hold), 32'd0);

        // Same image, byte_valid toggling
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        add_ck();
        run_image("t2", 1'b1);
        chk("t2_nwr_lit", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
            chk("t2_d1_lit", 32'(log_data[1]), 32'hABCDEF);
        end

        // Oversized count is rejected, then a good image recovers
        stream = '{8'h01, 8'h01};
        run_image("t3", 1'b0);
        chk("t3_err_lit", 32'(error), 32'd1);
        chk("t3_nwr_lit", 32'(log_data.size()), 32'd0);
        stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        add_ck();
        run_image("t3b", 1'b0);
        chk("t3b_done_lit", 32'(done), 32'd1);
        if (log_data.size() == 1) chk("t3b_d0_lit", 32'(log_data[0]), 32'hAABBCC);
        else chk("t3b_nwr_lit", 32'(log_data.size()), 32'd1);

        // Empty image
        stream = '{8'h00, 8'h00};
        add_ck();
        run_image("t4", 1'b0);
        chk("t4_done_lit", 32'(done), 32'd1);
        chk("t4_nwr_lit", 32'(log_data.size()), 32'd0);

        // start with a valid byte in DONE must not consume that byte
        stream = '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'h3C};
        add_ck();
        build_model();
        pulse_start(1'b1, 8'h00);
        send_stream(1'b0);
        finish_load("t5");
        if (log_data.size() == 1) chk("t5_d0_lit", 32'(log_data[0]), 32'h5AA53C);
        else chk("t5_nwr_lit", 32'(log_data.size()), 32'd1);

        // Reset asserted mid-word (after B1 of word 0)
        stream = '{8'h00, 8'h02, 8'h12, 8'h34};
        clear_expect();
        pulse_start(1'b0, 8'h00);
        send_stream(1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        chk("midrst_nwr", 32'(log_data.size()), 32'd0);
        reset = 1'b1;
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        add_ck();
        run_image("t6", 1'b0);
        chk("t6_nwr_lit", 32'(log_data.size()), 32'd2);

        // Largest accepted image: N == DEPTH
        stream = '{8'h01, 8'h00};
        for (int w = 0; w < 256; w++) begin
            stream.push_back(u8_t'(w));
            stream.push_back(~u8_t'(w));
            stream.push_back(u8_t'(w) ^ 8'h5A);
        end
        add_ck();
        run_image("t7", 1'b0);
        chk("t7_nwr_lit", 32'(log_data.size()), 32'd256);
        if (log_data.size() == 256) begin
            chk("t7_alast_lit", 32'(log_addr[255]), 32'd255);
            chk("t7_dlast_lit", 32'(log_data[255]), 32'hFF00A5);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: word is written, but the load fails
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h00};
        run_image("t8", 1'b0);
        chk("t8_err_lit", 32'(error), 32'd1);
        chk("t8_hold_lit", 32'(cpu_hold), 32'd1);
        if (log_data.size() == 1) chk("t8_d0_lit", 32'(log_data[0]), 32'h112233);
        else chk("t8_nwr_lit", 32'(log_data.size()), 32'd1);
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h01};
        run_image("t9", 1'b0);
        chk("t9_done_lit", 32'(done), 32'd1);
        chk("t9_hold_lit", 32'(cpu_hold), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
